rsff_resp_checker: RTL and testbench

- Synthesizable response checker: the observing end of the RS flip-flop stimulus interface.
- Runs a cycle-accurate golden RS model alongside a DUT flip-flop and samples the DUT's q every clock.
- Counts checks, mismatches and illegal r=s=1 inputs, then reports a pass/fail verdict after a programmed number of checks.
- Sits beside any RS flip-flop instance in the Triggers library, for on-board or bench self-check.

---
 rtl/rsff_resp_checker_if.sv | 28 ++
 rtl/rsff_resp_checker.sv | 84 ++++++++
 tb/tb_rsff_resp_checker.sv | 115 +++++++++++
 3 files changed

// File: rtl/rsff_resp_checker_if.sv
// rsff_resp_checker_if: stimulus-mirror and verdict signals between an RS flip-flop bench and its response checker.
interface rsff_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             r;
    logic             s;
    logic             dut_rst;
    logic             q_dut;
    logic             q_ref;
    logic             mismatch;
    logic             illegal;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        output start, r, s, dut_rst, q_dut,
        input  q_ref, mismatch, illegal, chk_cnt, err_cnt, busy, done, pass
    );

    modport slave (
        input  start, r, s, dut_rst, q_dut,
        output q_ref, mismatch, illegal, chk_cnt, err_cnt, busy, done, pass
    );
endinterface

// File: rtl/rsff_resp_checker.sv
// rsff_resp_checker: golden RS model run beside a DUT flip-flop, counting checks/errors and giving a pass verdict.
module rsff_resp_checker #(
    parameter int NUM_CHECKS     = 4,
    parameter int CNT_W          = 8,
    parameter bit INIT_Q         = 1'b0,
    parameter bit ILLEGAL_IS_ERR = 1'b1
) (
    input logic               clk,
    input logic               rst_syn,
    rsff_resp_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             q_ref, mismatch, illegal, busy, done, pass;
    logic [CNT_W-1:0] chk_cnt, err_cnt, chk_nxt, err_nxt;
    logic             ill, mm, q_nxt;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;

    // Compare against the pre-update model; a DUT reset cycle skips the compare.
    always_comb begin
        ill     = bus.r & bus.s;
        mm      = !bus.dut_rst && (bus.q_dut != q_ref);
        inc     = {1'b0, mm} + {1'b0, ill & ILLEGAL_IS_ERR};
        sum     = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, inc};
        err_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        chk_nxt = chk_cnt + CNT_W'(!bus.dut_rst);
        q_nxt   = bus.dut_rst ? 1'b0 :
                  (bus.s & !bus.r) ? 1'b1 :
                  (bus.r & !bus.s) ? 1'b0 : q_ref;
    end

    always_ff @(posedge clk) begin
        if (rst_syn) begin
            state    <= IDLE;
            q_ref    <= INIT_Q;
            mismatch <= 1'b0;
            illegal  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            chk_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            mismatch <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                    q_ref   <= INIT_Q;
                    chk_cnt <= '0;
                    err_cnt <= '0;
                end
                RUN: begin
                    mismatch <= mm;
                    illegal  <= ill;
                    q_ref    <= q_nxt;
                    chk_cnt  <= chk_nxt;
                    err_cnt  <= err_nxt;
                    if (chk_nxt == CNT_W'(NUM_CHECKS)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.q_ref    = q_ref;
    assign bus.mismatch = mismatch;
    assign bus.illegal  = illegal;
    assign bus.chk_cnt  = chk_cnt;
    assign bus.err_cnt  = err_cnt;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pass     = pass;
endmodule

// File: tb/tb_rsff_resp_checker.sv
// tb_rsff_resp_checker: vector table through a scoreboard queue, checking two checkers (illegal counted / not counted).
module tb_rsff_resp_checker;
    logic clk = 1'b0;
    logic rst_syn;
    always #5 clk = ~clk;

    rsff_resp_checker_if #(.CNT_W(8)) bus0 ();
    rsff_resp_checker_if #(.CNT_W(8)) bus1 ();

    rsff_resp_checker #(.NUM_CHECKS(4), .CNT_W(8), .INIT_Q(1'b0), .ILLEGAL_IS_ERR(1'b1))
        u0 (.clk(clk), .rst_syn(rst_syn), .bus(bus0.slave));
    rsff_resp_checker #(.NUM_CHECKS(4), .CNT_W(8), .INIT_Q(1'b0), .ILLEGAL_IS_ERR(1'b0))
        u1 (.clk(clk), .rst_syn(rst_syn), .bus(bus1.slave));

    assign bus1.start   = bus0.start;
    assign bus1.r       = bus0.r;
    assign bus1.s       = bus0.s;
    assign bus1.dut_rst = bus0.dut_rst;
    assign bus1.q_dut   = bus0.q_dut;

    typedef struct {
        logic rst, start, r, s, dr, qd;
        logic qr, mm, il;
        int   chk, err;
        logic busy, done, pass;
        int   err1;
        logic pass1;
    } vec_t;

    vec_t tbl[28];
    vec_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic cmp(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0d expected=%0d", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, start, r, s, dr, qd, qr, mm, il,
                                input int chk, err, input logic busy, done, pass,
                                input int err1, input logic pass1);
        vec_t v;
        v.rst = rst; v.start = start; v.r = r; v.s = s; v.dr = dr; v.qd = qd;
        v.qr = qr; v.mm = mm; v.il = il; v.chk = chk; v.err = err;
        v.busy = busy; v.done = done; v.pass = pass; v.err1 = err1; v.pass1 = pass1;
        return v;
    endfunction

    initial begin
        //            rst st r s dr qd | qr mm il chk err busy done pass err1 pass1
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,  0, 0); // reset
        tbl[1]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 0,  0, 0); // start
        tbl[2]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0,  1, 0, 0,  0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0,  1, 0, 0,  0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,  0, 0); // reset mid-run
        tbl[5]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 0,  0, 0); // clean run
        tbl[6]  = mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0,  1, 0, 0,  0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0,  1, 0, 0,  0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 0,   1, 0, 0, 3, 0,  1, 0, 0,  0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 4, 0,  0, 1, 1,  0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 4, 0,  0, 1, 1,  0, 1); // DONE holds
        tbl[11] = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 0,  0, 0); // stuck-at-0 run
        tbl[12] = mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0,  1, 0, 0,  0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0,  1, 0, 0,  0, 0);
        tbl[14] = mk(0, 0, 0, 1, 0, 0,   1, 0, 0, 3, 0,  1, 0, 0,  0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 4, 1,  0, 1, 0,  1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 4, 1,  0, 1, 0,  1, 0);
        tbl[17] = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 0,  0, 0); // illegal run
        tbl[18] = mk(0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0,  1, 0, 0,  0, 0);
        tbl[19] = mk(0, 1, 1, 1, 0, 1,   1, 0, 1, 2, 1,  1, 0, 0,  0, 0); // start ignored
        tbl[20] = mk(0, 1, 0, 0, 0, 1,   1, 0, 0, 3, 1,  1, 0, 0,  0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 4, 1,  0, 1, 0,  0, 1);
        tbl[22] = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 0,  0, 0); // dut_rst run
        tbl[23] = mk(0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0,  1, 0, 0,  0, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 2, 0,  1, 0, 0,  0, 0);
        tbl[25] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 2, 0,  1, 0, 0,  0, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 0,  1, 0, 0,  0, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 0,  0, 1, 1,  0, 1);

        rst_syn = 1'b0;
        bus0.start = 1'b0; bus0.r = 1'b0; bus0.s = 1'b0; bus0.dut_rst = 1'b0; bus0.q_dut = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 28; i++) begin
            vec_t e;
            rst_syn      = tbl[i].rst;
            bus0.start   = tbl[i].start;
            bus0.r       = tbl[i].r;
            bus0.s       = tbl[i].s;
            bus0.dut_rst = tbl[i].dr;
            bus0.q_dut   = tbl[i].qd;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            cmp("q_ref",    i, int'(bus0.q_ref),    int'(e.qr));
            cmp("mismatch", i, int'(bus0.mismatch), int'(e.mm));
            cmp("illegal",  i, int'(bus0.illegal),  int'(e.il));
            cmp("chk_cnt",  i, int'(bus0.chk_cnt),  e.chk);
            cmp("err_cnt",  i, int'(bus0.err_cnt),  e.err);
            cmp("busy",     i, int'(bus0.busy),     int'(e.busy));
            cmp("done",     i, int'(bus0.done),     int'(e.done));
            cmp("pass",     i, int'(bus0.pass),     int'(e.pass));
            cmp("err_cnt_noill", i, int'(bus1.err_cnt), e.err1);
            cmp("pass_noill",    i, int'(bus1.pass),    int'(e.pass1));
            cmp("illegal_noill", i, int'(bus1.illegal), int'(e.il));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
